antirebote_scan: RTL and testbench

Multi-channel debounce controller and event arbiter for the front-panel push-buttons. It shares one sample-tick prescaler among N raw button inputs and keeps a small stable-count per channel, so all buttons are debounced to a clean level. Accepted level changes are turned into press/release events. A round-robin arbiter presents those events one at a time to the control FSM over a valid/ready handshake.

---
 rtl/antirebote_scan.sv | 165 ++++++++++++++++
 tb/tb_antirebote_scan.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/antirebote_scan.sv
// Multi-channel push-button debouncer with a shared sample-tick prescaler and
// a round-robin arbiter that presents press/release events over valid/ready.
module antirebote_scan #(
  parameter int N            = 4,
  parameter int TICK_DIV     = 500,
  parameter int STABLE_TICKS = 100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         btn_in,
  output logic [N-1:0]         btn_out,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [$clog2(N)-1:0] evt_id,
  output logic                 evt_press,
  output logic [N-1:0]         overrun
);

  localparam int IDW = $clog2(N);
  localparam int PW  = $clog2(TICK_DIV);
  localparam int CW  = $clog2(STABLE_TICKS + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_TICKS - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SHOW = 1'b1;

  logic [N-1:0]   sync1;
  logic [N-1:0]   sync2;
  logic [PW-1:0]  presc;
  logic           tick;
  logic [CW-1:0]  cnt [N];
  logic [N-1:0]   accept;
  logic [N-1:0]   pend;
  logic [N-1:0]   pend_dir;
  logic [N-1:0]   clr;
  logic [IDW-1:0] last;
  logic [IDW-1:0] gnt_id;
  logic           gnt_any;
  logic [0:0]     state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign tick = (presc == PRESC_LAST);

  // A channel is accepted on the tick that would push its count past the limit.
  always_comb begin
    accept = '0;
    for (int i = 0; i < N; i++) begin
      accept[i] = tick && (sync2[i] != btn_out[i]) && (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
      btn_out <= '0;
    end else if (tick) begin
      for (int i = 0; i < N; i++) begin
        if (sync2[i] == btn_out[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i]     <= '0;
          btn_out[i] <= ~btn_out[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Round-robin search beginning just after the most recently granted channel.
  always_comb begin
    logic [IDW-1:0] idx;
    idx     = '0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int k = 0; k < N; k++) begin
      idx = IDW'((int'(last) + 1 + k) % N);
      if (!gnt_any && pend[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = idx;
      end
    end
  end

  always_comb begin
    clr = '0;
    if (state == IDLE && gnt_any) begin
      clr[gnt_id] = 1'b1;
    end
  end

  // A new event beats a same-cycle grant clear and is not counted as an overrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend     <= '0;
      pend_dir <= '0;
      overrun  <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (accept[i]) begin
          pend[i]     <= 1'b1;
          pend_dir[i] <= ~btn_out[i];
          if (pend[i] && !clr[i]) begin
            overrun[i] <= 1'b1;
          end
        end else if (clr[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      evt_valid <= 1'b0;
      evt_id    <= '0;
      evt_press <= 1'b0;
      last      <= IDW'(N - 1);
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            evt_id    <= gnt_id;
            evt_press <= pend_dir[gnt_id];
            last      <= gnt_id;
            evt_valid <= 1'b1;
            state     <= SHOW;
          end
        end
        SHOW: begin
          if (evt_ready) begin
            evt_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_antirebote_scan.sv
// Directed bench for antirebote_scan: debounce timing, event ordering,
// backpressure/overrun and asynchronous reset behaviour.
module tb_antirebote_scan;

  localparam int N            = 4;
  localparam int TICK_DIV     = 4;
  localparam int STABLE_TICKS = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] btn_in = '0;
  logic         evt_ready = 1'b0;
  logic [N-1:0] btn_out;
  logic         evt_valid;
  logic [1:0]   evt_id;
  logic         evt_press;
  logic [N-1:0] overrun;

  int checks   = 0;
  int failures = 0;

  int   got_n;
  int   got_id [8];
  logic got_press [8];

  antirebote_scan #(
    .N(N),
    .TICK_DIV(TICK_DIV),
    .STABLE_TICKS(STABLE_TICKS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btn_in),
    .btn_out(btn_out),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_id(evt_id),
    .evt_press(evt_press),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_valid(input int limit, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (evt_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_btn(input int ch, input logic level, input int limit, output int cyc);
    cyc = -1;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (btn_out[ch] === level) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic collect_events(input int cycles);
    got_n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (evt_valid === 1'b1) begin
        if (got_n < 8) begin
          got_id[got_n]    = int'(evt_id);
          got_press[got_n] = evt_press;
        end
        got_n++;
      end
    end
  endtask

  task automatic test_reset();
    bit seen;
    rst       = 1'b0;
    btn_in    = 4'($urandom);
    evt_ready = 1'($urandom);
    repeat (3) @(negedge clk);
    checks++;
    if (btn_out !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_btn_out got=%b expected=0000", btn_out);
    end
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_evt_valid got=%b expected=0", evt_valid);
    end
    checks++;
    if (evt_id !== 2'd0) begin
      failures++;
      $display("[TB] FAIL reset_evt_id got=%0d expected=0", evt_id);
    end
    checks++;
    if (evt_press !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_evt_press got=%b expected=0", evt_press);
    end
    checks++;
    if (overrun !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_overrun got=%b expected=0000", overrun);
    end
    btn_in    = '0;
    evt_ready = 1'b0;
    rst       = 1'b1;
    seen      = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (evt_valid !== 1'b0 || btn_out !== 4'b0000) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("[TB] FAIL idle_no_event got=activity expected=none");
    end
  endtask

  task automatic test_bounce();
    bit bad;
    bit ok;
    int cyc;
    int extra;
    evt_ready = 1'b1;
    bad = 1'b0;
    for (int t = 0; t < 60; t++) begin
      if (t % 6 == 0) btn_in[0] = ~btn_in[0];
      @(negedge clk);
      if (btn_out[0] !== 1'b0 || evt_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("[TB] FAIL bounce_quiet got=output_change expected=stable_0");
    end
    btn_in[0] = 1'b1;
    wait_btn(0, 1'b1, 40, cyc);
    checks++;
    if (cyc < 19 || cyc > 22) begin
      failures++;
      $display("[TB] FAIL bounce_delay got=%0d expected=19..22", cyc);
    end
    @(negedge clk);
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd0 || evt_press !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bounce_event got=v%b id%0d p%b expected=v1 id0 p1",
               evt_valid, evt_id, evt_press);
    end
    @(negedge clk);
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bounce_one_cycle got=%b expected=0", evt_valid);
    end
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (evt_valid === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("[TB] FAIL bounce_single_event got=%0d expected=0 extra", extra);
    end
    btn_in[0] = 1'b0;
    wait_valid(40, ok);
    checks++;
    if (!ok || evt_id !== 2'd0 || evt_press !== 1'b0 || btn_out[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL release_event got=ok%b id%0d p%b b%b expected=ok1 id0 p0 b0",
               ok, evt_id, evt_press, btn_out[0]);
    end
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    int cyc;
    evt_ready = 1'b1;
    btn_in[1] = 1'b1;
    btn_in[3] = 1'b1;
    cyc = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (btn_out[1] === 1'b1 || btn_out[3] === 1'b1) begin
        cyc = k;
        break;
      end
    end
    checks++;
    if (cyc < 0 || btn_out !== 4'b1010) begin
      failures++;
      $display("[TB] FAIL simul_btn_out got=%b expected=1010", btn_out);
    end
    @(negedge clk);
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd1 || evt_press !== 1'b1) begin
      failures++;
      $display("[TB] FAIL simul_first got=v%b id%0d p%b expected=v1 id1 p1",
               evt_valid, evt_id, evt_press);
    end
    @(negedge clk);
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL simul_gap got=%b expected=0", evt_valid);
    end
    @(negedge clk);
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd3 || evt_press !== 1'b1) begin
      failures++;
      $display("[TB] FAIL simul_second got=v%b id%0d p%b expected=v1 id3 p1",
               evt_valid, evt_id, evt_press);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit ok;
    bit bad;
    evt_ready = 1'b0;
    btn_in[2] = 1'b1;
    wait_valid(40, ok);
    checks++;
    if (!ok || evt_id !== 2'd2 || evt_press !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_shown got=ok%b id%0d p%b expected=ok1 id2 p1",
               ok, evt_id, evt_press);
    end
    bad = 1'b0;
    btn_in[0] = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (evt_valid !== 1'b1 || evt_id !== 2'd2 || evt_press !== 1'b1) bad = 1'b1;
    end
    btn_in[0] = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (evt_valid !== 1'b1 || evt_id !== 2'd2 || evt_press !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("[TB] FAIL bp_hold got=changed expected=id2 held");
    end
    checks++;
    if (overrun !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL bp_overrun got=%b expected=0001", overrun);
    end
    checks++;
    if (btn_out !== 4'b1110) begin
      failures++;
      $display("[TB] FAIL bp_btn_out got=%b expected=1110", btn_out);
    end
    evt_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_accept got=%b expected=0", evt_valid);
    end
    collect_events(20);
    checks++;
    if (got_n != 1 || got_id[0] != 0 || got_press[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_latest got=n%0d id%0d p%b expected=n1 id0 p0",
               got_n, got_id[0], got_press[0]);
    end
  endtask

  task automatic test_fairness();
    bit ok;
    evt_ready = 1'b1;
    btn_in[3] = 1'b0;
    wait_valid(40, ok);
    checks++;
    if (!ok || evt_id !== 2'd3 || evt_press !== 1'b0) begin
      failures++;
      $display("[TB] FAIL fair_setup got=ok%b id%0d p%b expected=ok1 id3 p0",
               ok, evt_id, evt_press);
    end
    repeat (10) @(negedge clk);
    btn_in[0] = 1'b1;
    btn_in[1] = 1'b0;
    btn_in[3] = 1'b1;
    collect_events(40);
    checks++;
    if (got_n != 3 || got_id[0] != 0 || got_id[1] != 1 || got_id[2] != 3 ||
        got_press[0] !== 1'b1 || got_press[1] !== 1'b0 || got_press[2] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL fair_order_013 got=n%0d ids %0d,%0d,%0d expected=n3 ids 0,1,3",
               got_n, got_id[0], got_id[1], got_id[2]);
    end
    btn_in[1] = 1'b1;
    wait_valid(40, ok);
    checks++;
    if (!ok || evt_id !== 2'd1 || evt_press !== 1'b1) begin
      failures++;
      $display("[TB] FAIL fair_last1 got=ok%b id%0d p%b expected=ok1 id1 p1",
               ok, evt_id, evt_press);
    end
    repeat (5) @(negedge clk);
    btn_in[0] = 1'b0;
    btn_in[3] = 1'b0;
    collect_events(40);
    checks++;
    if (got_n != 2 || got_id[0] != 3 || got_id[1] != 0 ||
        got_press[0] !== 1'b0 || got_press[1] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL fair_order_30 got=n%0d ids %0d,%0d expected=n2 ids 3,0",
               got_n, got_id[0], got_id[1]);
    end
  endtask

  task automatic test_reset_mid_show();
    bit ok;
    bit bad;
    evt_ready = 1'b0;
    btn_in[2] = 1'b0;
    wait_valid(40, ok);
    checks++;
    if (!ok || evt_id !== 2'd2 || evt_press !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rst_show_setup got=ok%b id%0d p%b expected=ok1 id2 p0",
               ok, evt_id, evt_press);
    end
    btn_in[1] = 1'b0;
    bad = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (evt_valid !== 1'b1 || evt_id !== 2'd2) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("[TB] FAIL rst_show_hold got=changed expected=id2 held");
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (evt_valid !== 1'b0 || overrun !== 4'b0000 || btn_out !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL rst_async got=v%b ov%b b%b expected=v0 ov0000 b0000",
               evt_valid, overrun, btn_out);
    end
    @(negedge clk);
    rst       = 1'b1;
    evt_ready = 1'b1;
    bad       = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (evt_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("[TB] FAIL rst_lost_event got=event expected=none");
    end
    checks++;
    if (btn_out !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL rst_btn_out got=%b expected=0000", btn_out);
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_simultaneous();
    test_backpressure();
    test_fairness();
    test_reset_mid_show();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
